prefix_add4: RTL and testbench

PREFIX_ADD4 -- requirements
Module: prefix_add4

---
 rtl/prefix_add4_pkg.sv | 19 +
 rtl/prefix_add4_if.sv | 20 ++
 rtl/prefix_gp_cell.sv | 13 +
 rtl/prefix_add4.sv | 68 ++++++
 tb/tb_prefix_add4.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/prefix_add4_pkg.sv
// Shared constants and types for the 4-bit Kogge-Stone adder.
// Optional signed-overflow output is enabled by PREFIX_ADD4_OVF_EN.
package prefix_add4_pkg;

  localparam int WIDTH  = 4;
  // Carry-in occupies prefix position 0, operand bit i sits at position i+1.
  localparam int NODES  = WIDTH + 1;
  localparam int LEVELS = 3;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int spanOf(input int level);
    return 1 << level;
  endfunction

endpackage

// File: rtl/prefix_add4_if.sv
// Operand/result bundle for prefix_add4; ovf exists only with PREFIX_ADD4_OVF_EN.
interface prefix_add4_if;
  import prefix_add4_pkg::*;

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cIn;
  logic [WIDTH-1:0] s;
  logic             cOut;
`ifdef PREFIX_ADD4_OVF_EN
  logic             ovf;

  modport master (output x, y, cIn, input  s, cOut, ovf);
  modport slave  (input  x, y, cIn, output s, cOut, ovf);
`else
  modport master (output x, y, cIn, input  s, cOut);
  modport slave  (input  x, y, cIn, output s, cOut);
`endif

endinterface

// File: rtl/prefix_gp_cell.sv
// Prefix combine (G,P)o(G',P') = (G | P&G', P&P'); hi is the more significant span.
module prefix_gp_cell
  import prefix_add4_pkg::*;
(
  input  gp_t hi,
  input  gp_t lo,
  output gp_t o
);

  assign o.g = hi.g | (hi.p & lo.g);
  assign o.p = hi.p & lo.p;

endmodule

// File: rtl/prefix_add4.sv
// 4-bit registered adder with a 3-level Kogge-Stone carry network.
// Define PREFIX_ADD4_OVF_EN to add the registered signed-overflow output.
module prefix_add4
  import prefix_add4_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  prefix_add4_if.slave  bus
);

  gp_t [LEVELS:0][NODES-1:0] lvl;
  logic [WIDTH-1:0]          pBit;
  logic [NODES-1:0]          carry;
  logic [WIDTH-1:0]          sumNxt;
  logic                      unusedTopP;

  // Leaf level: carry-in acts as a generate with no propagate.
  assign lvl[0][0] = '{g: bus.cIn, p: 1'b0};

  for (genvar i = 0; i < WIDTH; i++) begin : gLeaf
    assign pBit[i]     = bus.x[i] ^ bus.y[i];
    assign lvl[0][i+1] = '{g: bus.x[i] & bus.y[i], p: pBit[i]};
  end

  for (genvar lv = 0; lv < LEVELS; lv++) begin : gLevel
    for (genvar j = 0; j < NODES; j++) begin : gNode
      if (j >= spanOf(lv)) begin : gCell
        prefix_gp_cell uCell (
          .hi (lvl[lv][j]),
          .lo (lvl[lv][j-spanOf(lv)]),
          .o  (lvl[lv+1][j])
        );
      end else begin : gPass
        assign lvl[lv+1][j] = lvl[lv][j];
      end
    end
  end

  // After the last level every position holds the group generate down to cIn.
  for (genvar j = 0; j < NODES; j++) begin : gCarry
    assign carry[j] = lvl[LEVELS][j].g;
  end

  assign sumNxt = pBit ^ carry[WIDTH-1:0];

  always_comb begin
    unusedTopP = 1'b0;
    for (int j = 0; j < NODES; j++) unusedTopP = unusedTopP ^ lvl[LEVELS][j].p;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.s    <= '0;
      bus.cOut <= 1'b0;
    end else begin
      bus.s    <= sumNxt;
      bus.cOut <= carry[WIDTH];
    end
  end

`ifdef PREFIX_ADD4_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.ovf <= 1'b0;
    else        bus.ovf <= carry[WIDTH] ^ carry[WIDTH-1];
  end
`endif

endmodule

// File: tb/tb_prefix_add4.sv
// Self-checking bench for prefix_add4: directed table, exhaustive sweep,
// random vectors vs. an arithmetic model, reset and back-to-back sequences.
module tb_prefix_add4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nChk = 0;
  int   nPass = 0;

`ifdef PREFIX_ADD4_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  prefix_add4_if bus();

  prefix_add4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic       c;
    logic [3:0] expS;
    logic       expC;
    logic       expV;
  } vec_t;

  function automatic logic dutOvf();
`ifdef PREFIX_ADD4_OVF_EN
    return bus.ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: plain integer addition, overflow from operand/result signs.
  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic c);
    int   sum;
    logic v;
    sum = int'(a) + int'(b) + int'(c);
    v   = (a[3] == b[3]) && (((sum >> 3) & 1) != int'(a[3]));
    return {v, sum[4:0]};
  endfunction

  task automatic check(input string nm, input logic [3:0] eS, input logic eC, input logic eV);
    logic [5:0] act, exp;
    act = {dutOvf(), bus.cOut, bus.s};
    exp = {eV & OVF_ON, eC, eS};
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got ovf/cOut/s=%b/%b/%h, want %b/%b/%h",
                  nm, act[5], act[4], act[3:0], exp[5], exp[4], exp[3:0]);
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c);
    @(negedge clk);
    bus.x = a; bus.y = b; bus.cIn = c;
  endtask

  task automatic capture();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  logic [5:0] m;
  logic [3:0] ra, rb;
  logic       rc;

  initial begin
    bus.x = 4'h0; bus.y = 4'h0; bus.cIn = 1'b0;

    tbl.push_back('{4'hE, 4'h1, 1'b0, 4'hF, 1'b0, 1'b0});
    tbl.push_back('{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0});
    tbl.push_back('{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0});
    tbl.push_back('{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1});
    tbl.push_back('{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1});
    tbl.push_back('{4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0});
    tbl.push_back('{4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0});
    tbl.push_back('{4'h7, 4'h7, 1'b1, 4'hF, 1'b0, 1'b1});
    tbl.push_back('{4'h8, 4'h7, 1'b1, 4'h0, 1'b1, 1'b0});

    // Reset state, including across a clock edge with live inputs.
    #2;
    check("reset_initial", 4'h0, 1'b0, 1'b0);
    drive(4'hF, 4'hF, 1'b1);
    capture();
    check("reset_held_edge", 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.x = 4'hE; bus.y = 4'h1; bus.cIn = 1'b0;
    capture();
    check("first_edge_after_reset", 4'hF, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      drive(tbl[i].x, tbl[i].y, tbl[i].c);
      capture();
      check($sformatf("table_%0d", i), tbl[i].expS, tbl[i].expC, tbl[i].expV);
    end

    // Exhaustive sweep, one combination per cycle.
    for (int k = 0; k < 512; k++) begin
      ra = 4'(k >> 5); rb = 4'(k >> 1); rc = k[0];
      drive(ra, rb, rc);
      capture();
      m = model(ra, rb, rc);
      check($sformatf("sweep_%h_%h_%b", ra, rb, rc), m[3:0], m[4], m[5]);
    end

    for (int k = 0; k < 200; k++) begin
      ra = 4'($urandom_range(15)); rb = 4'($urandom_range(15)); rc = 1'($urandom_range(1));
      drive(ra, rb, rc);
      capture();
      m = model(ra, rb, rc);
      check($sformatf("rand_%h_%h_%b", ra, rb, rc), m[3:0], m[4], m[5]);
    end

    // Mid-operation async reset between edges clears outputs at once.
    drive(4'h8, 4'h8, 1'b0);
    capture();
    check("pre_reset_nonzero", 4'h0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.x = 4'h7; bus.y = 4'h1; bus.cIn = 1'b0;
    #1;
    check("reset_released_no_edge", 4'h0, 1'b0, 1'b0);
    capture();
    check("capture_after_release", 4'h8, 1'b0, 1'b1);

    // Back-to-back changes: results appear on consecutive cycles.
    drive(4'hE, 4'h1, 1'b0);
    capture();
    check("b2b_0", 4'hF, 1'b0, 1'b0);
    drive(4'hF, 4'h1, 1'b0);
    capture();
    check("b2b_1", 4'h0, 1'b1, 1'b0);
    drive(4'h0, 4'h0, 1'b1);
    capture();
    check("b2b_2", 4'h1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
